serial_mag_comp: RTL and testbench
==================================

SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, the number of bit pairs per comparison (legal range 2..16).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port nRST, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port START, input, 1 bit, the request to begin a comparison.
REQ-005 The block SHALL have port BIT_VLD, input, 1 bit; when high, A_BIT and B_BIT carry one valid bit pair.
REQ-006 The block SHALL have port A_BIT, input, 1 bit, serial operand A, MSB first.
REQ-007 The block SHALL have port B_BIT, input, 1 bit, serial operand B, MSB first.
REQ-008 The block SHALL have port R, output, 3 bits, the registered result: R[2] = A>B, R[1] = A==B, R[0] = A<B.
REQ-009 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse marking that R has been updated.
REQ-010 The block SHALL have port BUSY, output, 1 bit, high while a comparison is in progress.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and SHIFT; BUSY SHALL be high only in SHIFT.
REQ-012 In IDLE, START=1 SHALL move the FSM to SHIFT on the next edge, clearing the bit counter to 0 and setting the internal decision to "equal".
REQ-013 In IDLE, BIT_VLD SHALL be ignored, including a BIT_VLD that arrives in the same cycle as START.
REQ-014 In SHIFT, START SHALL be ignored; the comparison in progress SHALL NOT be restarted.
REQ-015 In SHIFT, each edge with BIT_VLD=1 SHALL consume one bit pair and increment the counter; edges with BIT_VLD=0 SHALL leave all state unchanged, so gaps of any length are legal.
REQ-016 While the decision is "equal", a consumed pair with A_BIT=1, B_BIT=0 SHALL set the decision to "greater", and A_BIT=0, B_BIT=1 SHALL set it to "less".
REQ-017 Once the decision is "greater" or "less", later bit pairs SHALL be consumed and counted but SHALL NOT change it.
REQ-018 On the edge that consumes the WIDTH-th pair, the block SHALL, in the same edge:
- load R with the one-hot decision;
- drive DONE high for exactly one cycle;
- return the FSM to IDLE.
REQ-019 Latency SHALL be zero cycles after the last valid pair: DONE and the new R SHALL be visible in the cycle immediately after that edge.
REQ-020 R SHALL hold its value between comparisons and change only under REQ-018 or reset.
REQ-021 START SHALL be accepted in the cycle in which DONE is high, giving back-to-back comparisons.
REQ-022 After its first completion, R SHALL always be one-hot.

Reset
REQ-023 While nRST=0, regardless of CLK, the block SHALL force:
- the FSM to IDLE;
- the counter to 0;
- the decision to "equal";
- R = 3'b000, DONE = 0, BUSY = 0.
REQ-024 Asserting nRST during SHIFT SHALL abandon the comparison; no DONE SHALL follow for it.
REQ-025 After nRST is deasserted, a new START SHALL be required before any bit pair is consumed.

Verification
REQ-026 The bench SHALL cover these directed scenarios (WIDTH=4):
- Greater: START, then pairs for A=0100, B=0011 with BIT_VLD high for 4 cycles -> DONE one cycle after the 4th pair, R=100, BUSY low.
- Equal: A=1111, B=1111, then A=0000, B=0000 back to back, START given in the DONE cycle -> both give R=010, each with a single DONE pulse.
- Less with early decision and gaps: A=0111, B=1000, BIT_VLD toggled 1,0,0,1,1,0,1 -> R=001 only after the 4th valid pair, no DONE before it.
- Ignored controls: START pulsed mid-SHIFT, and BIT_VLD with START in IDLE, for A=0101, B=0100 -> exactly 4 pairs counted, R=100.
- Reset mid-operation: nRST low after 2 pairs, asynchronous to CLK -> R=000, DONE=0, BUSY=0 at once; a fresh START with A=0011, B=0011 -> R=010.

Source files
------------

// File: rtl/serial_mag_comp.sv
// Serial magnitude comparator.
// Two operands arrive one bit pair per valid cycle, MSB first. The first
// differing pair decides the ordering; the remaining pairs are still counted
// so the block knows when the operand has ended. After WIDTH pairs the
// one-hot result {A>B, A==B, A<B} is registered and DONE pulses once.
module serial_mag_comp #(
    parameter int WIDTH = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       START,
    input  logic       BIT_VLD,
    input  logic       A_BIT,
    input  logic       B_BIT,
    output logic [2:0] R,
    output logic       DONE,
    output logic       BUSY
);

    // Counter wide enough to hold 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Ordering decided so far; stays EQ until the first differing pair.
    typedef enum logic [1:0] {
        DEC_EQ = 2'd0,
        DEC_GT = 2'd1,
        DEC_LT = 2'd2
    } dec_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    dec_t            dec_reg, dec_next;
    logic [2:0]      r_reg, r_next;
    logic            done_reg, done_next;
    dec_t            dec_pair;

    // One-hot encoding of a decision as presented on R.
    function automatic logic [2:0] dec_to_onehot(input dec_t d);
        logic [2:0] oh;
        case (d)
            DEC_GT:  oh = 3'b100;
            DEC_LT:  oh = 3'b001;
            default: oh = 3'b010;
        endcase
        return oh;
    endfunction

    // Decision after folding in the pair currently on A_BIT/B_BIT. Only an
    // undecided (equal) comparison can be changed; later pairs are inert.
    always_comb begin
        dec_pair = dec_reg;
        if (dec_reg == DEC_EQ) begin
            if (A_BIT && !B_BIT) begin
                dec_pair = DEC_GT;
            end else if (!A_BIT && B_BIT) begin
                dec_pair = DEC_LT;
            end
        end
    end

    // Next-state logic: START only matters in IDLE, BIT_VLD only in SHIFT.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dec_next   = dec_reg;
        r_next     = r_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // A BIT_VLD coinciding with START is deliberately dropped.
                if (START) begin
                    state_next = SHIFT;
                    count_next = '0;
                    dec_next   = DEC_EQ;
                end
            end

            SHIFT: begin
                // Cycles without BIT_VLD hold everything, so gaps are free.
                if (BIT_VLD) begin
                    count_next = count_reg + CW'(1);
                    dec_next   = dec_pair;
                    if (count_reg == LAST_IDX) begin
                        // Last pair: publish result on this same edge.
                        r_next     = dec_to_onehot(dec_pair);
                        done_next  = 1'b1;
                        state_next = IDLE;
                        count_next = '0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
                dec_next   = DEC_EQ;
            end
        endcase
    end

    // State and result registers; reset abandons any comparison at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            count_reg <= '0;
            dec_reg   <= DEC_EQ;
            r_reg     <= 3'b000;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            dec_reg   <= dec_next;
            r_reg     <= r_next;
            done_reg  <= done_next;
        end
    end

    assign R    = r_reg;
    assign DONE = done_reg;
    assign BUSY = (state_reg == SHIFT);

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp (WIDTH=4): directed scenarios
// followed by randomized back-to-back comparisons with random gaps. The
// expected result comes from comparing the operands as integers.
module tb_serial_mag_comp;

    localparam int W = 4;

    logic       CLK;
    logic       nRST;
    logic       START;
    logic       BIT_VLD;
    logic       A_BIT;
    logic       B_BIT;
    logic [2:0] R;
    logic       DONE;
    logic       BUSY;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_r;     // value R must hold right now
    int gaps[W];

    serial_mag_comp #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .START  (START),
        .BIT_VLD(BIT_VLD),
        .A_BIT  (A_BIT),
        .B_BIT  (B_BIT),
        .R      (R),
        .DONE   (DONE),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: ordering of two unsigned numbers as the one-hot R code.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full comparison. START is raised on entry, so calling this right
    // after a previous call exercises START in the DONE cycle.
    // idle_vld: present a (would-be-deciding) pair alongside START.
    // mid_start: pulse START during SHIFT, both in a gap and with a pair.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit idle_vld, input bit mid_start, input string tag);
        logic [2:0] want;
        want    = ref_cmp(a, b);
        START   = 1'b1;
        BIT_VLD = idle_vld;
        A_BIT   = 1'b0;
        B_BIT   = 1'b1;
        step();
        START   = 1'b0;
        chk({tag, " busy_after_start"}, BUSY, 1'b1);
        chk({tag, " done_single"}, DONE, 1'b0);
        chk({tag, " r_hold_start"}, R, exp_r);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < gaps[W - 1 - i]; g++) begin
                BIT_VLD = 1'b0;
                A_BIT   = $urandom_range(0, 1);
                B_BIT   = $urandom_range(0, 1);
                START   = mid_start;
                step();
                chk({tag, " gap_done"}, DONE, 1'b0);
                chk({tag, " gap_busy"}, BUSY, 1'b1);
            end
            BIT_VLD = 1'b1;
            A_BIT   = a[i];
            B_BIT   = b[i];
            START   = mid_start && (i == 1);
            step();
            START   = 1'b0;
            BIT_VLD = 1'b0;
            if (i > 0) begin
                chk({tag, " early_done"}, DONE, 1'b0);
                chk({tag, " mid_busy"}, BUSY, 1'b1);
                chk({tag, " r_hold_mid"}, R, exp_r);
            end
        end
        exp_r = want;
        chk({tag, " done"}, DONE, 1'b1);
        chk({tag, " r"}, R, exp_r);
        chk({tag, " busy_end"}, BUSY, 1'b0);
        $display("cmp %s a=%b b=%b r=%b want=%b", tag, a, b, R, want);
    endtask

    // Idle cycles with noise on the data inputs: nothing may change.
    task automatic idle_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            START   = 1'b0;
            BIT_VLD = $urandom_range(0, 1);
            A_BIT   = $urandom_range(0, 1);
            B_BIT   = $urandom_range(0, 1);
            step();
            chk({tag, " idle_busy"}, BUSY, 1'b0);
            chk({tag, " idle_done"}, DONE, 1'b0);
            chk({tag, " idle_r"}, R, exp_r);
        end
    endtask

    initial begin
        nRST    = 1'b0;
        START   = 1'b0;
        BIT_VLD = 1'b0;
        A_BIT   = 1'b0;
        B_BIT   = 1'b0;
        exp_r   = 3'b000;
        #12;
        chk("reset r", R, 3'b000);
        chk("reset done", DONE, 1'b0);
        chk("reset busy", BUSY, 1'b0);
        nRST = 1'b1;
        step();

        // Greater, no gaps.
        foreach (gaps[k]) gaps[k] = 0;
        run_cmp(4'b0100, 4'b0011, 1'b0, 1'b0, "greater");
        idle_cycles(2, "greater");

        // Equal twice, second START in the DONE cycle.
        run_cmp(4'b1111, 4'b1111, 1'b0, 1'b0, "equal1");
        run_cmp(4'b0000, 4'b0000, 1'b0, 1'b0, "equal2");
        step();
        chk("equal2 done_single", DONE, 1'b0);
        chk("equal2 r_hold", R, 3'b010);

        // Less, decided on the first pair, BIT_VLD 1,0,0,1,1,0,1.
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1;
        run_cmp(4'b0111, 4'b1000, 1'b0, 1'b0, "less_gaps");
        idle_cycles(1, "less_gaps");

        // Ignored controls: BIT_VLD with START in IDLE, START mid-SHIFT.
        gaps[0] = 0; gaps[1] = 0; gaps[2] = 1; gaps[3] = 0;
        run_cmp(4'b0101, 4'b0100, 1'b1, 1'b1, "ignored");
        idle_cycles(1, "ignored");

        // Reset mid-operation, asserted between clock edges.
        foreach (gaps[k]) gaps[k] = 0;
        START = 1'b1;
        step();
        START   = 1'b0;
        BIT_VLD = 1'b1;
        A_BIT   = 1'b1;
        B_BIT   = 1'b1;
        step();
        step();
        #3;
        nRST = 1'b0;
        #1;
        exp_r = 3'b000;
        chk("rst_mid r", R, 3'b000);
        chk("rst_mid done", DONE, 1'b0);
        chk("rst_mid busy", BUSY, 1'b0);
        step();
        #2;
        nRST = 1'b1;
        // Pairs without START after reset must not be consumed.
        for (int k = 0; k < W + 1; k++) begin
            BIT_VLD = 1'b1;
            A_BIT   = 1'b1;
            B_BIT   = 1'b0;
            step();
            chk("post_rst done", DONE, 1'b0);
            chk("post_rst busy", BUSY, 1'b0);
            chk("post_rst r", R, 3'b000);
        end
        BIT_VLD = 1'b0;
        run_cmp(4'b0011, 4'b0011, 1'b0, 1'b0, "after_rst");

        // Randomized back-to-back comparisons with random gaps.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = (n % 4 == 0) ? ra : W'($urandom);
            foreach (gaps[k]) gaps[k] = $urandom_range(0, 2);
            run_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
